// File: rtl/hamming_bit_serializer_pkg.sv
// Shared types and defaults for the bit-serial Hamming feeder.
// Used by hamming_bit_serializer (optional feature macro: HAMMING_SER_PARITY_EN).
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ser_state_t;

  localparam int unsigned N_BITS_DEF = 16000;
  localparam int unsigned WORD_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 14;

  // Number of bits needed to hold values 0..value-1.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < value) begin
        res = 32'(i + 1);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_bit_serializer_word_buf.sv
// One-entry fall-through skid buffer for garbler/evaluator word pairs.
// Input words pass straight through when the consumer is ready and the entry is empty.
module hamming_word_buf #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept_s;

  assign in_ready_o  = en_i & (~full_q | out_ready_i);
  assign accept_s    = in_valid_i & in_ready_o;
  assign out_valid_o = full_q | (en_i & in_valid_i);
  assign out_data_o  = full_q ? data_q : in_data_i;

  // Entry occupancy: refill while draining, capture only when the word cannot bypass.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (full_q) begin
      if (out_ready_i) begin
        full_d = accept_s;
        data_d = in_data_i;
      end else begin
        full_d = 1'b1;
      end
    end else if (accept_s && !out_ready_i) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else begin
      full_d = 1'b0;
    end
  end

  // Entry registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/hamming_bit_serializer.sv
// Word-to-bit serializer feeding the bit-serial Hamming distance core, one bit pair per clock.
// Define HAMMING_SER_PARITY_EN to add the running parity output.
module hamming_bit_serializer
  import hamming_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] g_word_i,
  input  logic [WORD_W-1:0] e_word_i,
  output logic              core_clr_o,
  output logic              g_bit_o,
  output logic              e_bit_o,
  output logic              bit_valid_o,
  output logic [CNT_W-1:0]  bit_cnt_o,
  output logic              frame_done_o
`ifdef HAMMING_SER_PARITY_EN
  ,
  output logic              parity_o
`endif
);

  localparam int unsigned N_WORDS = (N_BITS + WORD_W - 1) / WORD_W;
  localparam int unsigned SH_W    = clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] WORDS_MAX = CNT_W'(N_WORDS);
  localparam logic [SH_W-1:0]  SH_FULL   = SH_W'(WORD_W);

  if (clog2(N_BITS + 1) > CNT_W) begin : g_cnt_w_check
    $error("CNT_W too narrow: 2**CNT_W must exceed N_BITS");
  end
  if (WORD_W < 1 || WORD_W > 64) begin : g_word_w_check
    $error("WORD_W must be in 1..64");
  end

  ser_state_t state_q, state_d;
  logic [WORD_W-1:0] g_sh_q, g_sh_d, e_sh_q, e_sh_d;
  logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, words_q, words_d;
  logic core_clr_q, core_clr_d, bit_valid_q, bit_valid_d, frame_done_q, frame_done_d;
  logic run_ph_s, emit_s, finish_s, sh_need_s, buf_en_s, buf_ready_s, buf_valid_s, load_s, accept_s;
  logic [2*WORD_W-1:0] buf_data_s;

  assign run_ph_s    = (state_q == CLR) || (state_q == RUN);
  assign emit_s      = (state_q == RUN) && (sh_cnt_q != '0);
  assign finish_s    = emit_s && (bit_cnt_q == LAST_BIT);
  assign sh_need_s   = (sh_cnt_q == '0) || (emit_s && (sh_cnt_q == SH_W'(1'b1)));
  // Stop taking words once the frame has all it needs, so surplus words stay upstream.
  assign buf_en_s    = run_ph_s && (words_q < WORDS_MAX) && !finish_s;
  assign buf_ready_s = run_ph_s && sh_need_s && !finish_s;
  assign load_s      = buf_ready_s && buf_valid_s;
  assign accept_s    = in_valid_i && in_ready_o;

  hamming_word_buf #(.DATA_W(2 * WORD_W)) u_word_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (buf_en_s),
    .flush_i     (finish_s),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   ({e_word_i, g_word_i}),
    .out_valid_o (buf_valid_s),
    .out_ready_i (buf_ready_s),
    .out_data_o  (buf_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = CLR;  else state_d = IDLE;
      CLR:     state_d = RUN;
      RUN:     if (finish_s) state_d = DONE; else state_d = RUN;
      DONE:    if (start_i) state_d = CLR;  else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values; counters clear on the way into CLR.
  always_comb begin
    g_sh_d    = g_sh_q;
    e_sh_d    = e_sh_q;
    sh_cnt_d  = sh_cnt_q;
    bit_cnt_d = bit_cnt_q;
    words_d   = words_q;
    if (finish_s) begin
      g_sh_d   = '0;
      e_sh_d   = '0;
      sh_cnt_d = '0;
    end else if (load_s) begin
      g_sh_d   = buf_data_s[WORD_W-1:0];
      e_sh_d   = buf_data_s[2*WORD_W-1:WORD_W];
      sh_cnt_d = SH_FULL;
    end else if (emit_s) begin
      g_sh_d   = g_sh_q >> 1;
      e_sh_d   = e_sh_q >> 1;
      sh_cnt_d = sh_cnt_q - SH_W'(1'b1);
    end else begin
      sh_cnt_d = sh_cnt_q;
    end
    if (state_d == CLR) begin
      bit_cnt_d = '0;
      words_d   = '0;
    end else begin
      if (emit_s) bit_cnt_d = bit_cnt_q + CNT_W'(1'b1);
      else        bit_cnt_d = bit_cnt_q;
      if (accept_s) words_d = words_q + CNT_W'(1'b1);
      else          words_d = words_q;
    end
    core_clr_d   = (state_d == CLR);
    frame_done_d = (state_d == DONE);
    bit_valid_d  = (sh_cnt_d != '0);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      g_sh_q       <= '0;
      e_sh_q       <= '0;
      sh_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      words_q      <= '0;
      core_clr_q   <= 1'b0;
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      g_sh_q       <= g_sh_d;
      e_sh_q       <= e_sh_d;
      sh_cnt_q     <= sh_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      words_q      <= words_d;
      core_clr_q   <= core_clr_d;
      bit_valid_q  <= bit_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The shift register empties to zero, so its LSBs double as the idle-safe bit outputs.
  assign g_bit_o      = g_sh_q[0];
  assign e_bit_o      = e_sh_q[0];
  assign bit_valid_o  = bit_valid_q;
  assign bit_cnt_o    = bit_cnt_q;
  assign core_clr_o   = core_clr_q;
  assign frame_done_o = frame_done_q;

`ifdef HAMMING_SER_PARITY_EN
  logic parity_q, parity_d;

  // Running parity of the frame's Hamming count.
  always_comb begin
    if (state_d == CLR) parity_d = 1'b0;
    else if (emit_s)    parity_d = parity_q ^ g_sh_q[0] ^ e_sh_q[0];
    else                parity_d = parity_q;
  end

  // Parity register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) parity_q <= 1'b0;
    else         parity_q <= parity_d;
  end

  assign parity_o = parity_q;
`endif

endmodule
